// File: rtl/nvme_fifo_pkg.sv
// Shared constants and helpers for the NVMe packet FIFO and its RAM.
package nvme_fifo_pkg;

  localparam logic ZERO = 1'b0;
  localparam logic ONE  = 1'b1;

  localparam int unsigned PAR_MAX = 256;

  function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned words);
    return (ptr + 1 == words) ? 0 : ptr + 1;
  endfunction

  // Even parity: the returned bit makes the total number of ones even.
  function automatic logic even_par(input logic [PAR_MAX-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/nvme_fifo_ram.sv
// Simple dual-port RAM, one write port and one registered read port.
module nvme_fifo_ram #(
  parameter int unsigned width  = 9,
  parameter int unsigned words  = 256,
  parameter int unsigned awidth = $clog2(words)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [awidth-1:0] waddr,
  input  logic [width-1:0]  wdata,
  input  logic              re,
  input  logic [awidth-1:0] raddr,
  output logic [width-1:0]  rdata
);

  logic [width-1:0] mem [words];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/nvme_pkt_fifo.sv
// Packet FIFO with commit/discard, auto-drop of overflowing packets and sticky errors.
// Define NVME_PKT_FIFO_PARITY_EN to store and check an even-parity bit per entry.
module nvme_pkt_fifo
  import nvme_fifo_pkg::*;
#(
  parameter int unsigned width              = 8,
  parameter int unsigned words              = 256,
  parameter int unsigned almost_full_thresh = 0,
  parameter int unsigned max_pkts           = 64,
  parameter int unsigned awidth             = $clog2(words),
  parameter int unsigned pwidth             = $clog2(max_pkts + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic [width-1:0]  din,
  input  logic              din_eop,
  input  logic              discard,
  input  logic              pop,
  input  logic              flush,
  input  logic              err_clr,
  output logic              dval,
  output logic [width-1:0]  dout,
  output logic              dout_eop,
  output logic              full,
  output logic              almost_full,
  output logic [awidth:0]   used,
  output logic [pwidth-1:0] pkt_cnt,
  output logic              pkt_drop,
  output logic              overflow,
  output logic              perr
);

  localparam int unsigned CW = awidth + 1;
  localparam logic [awidth:0] DEPTH = CW'(words);
  localparam logic AF_RST = (almost_full_thresh >= words);
`ifdef NVME_PKT_FIFO_PARITY_EN
  localparam int unsigned DW = width + 2;
`else
  localparam int unsigned DW = width + 1;
`endif

  logic [awidth-1:0] wptr_q, cptr_q, rptr_q;
  logic [awidth:0]   used_q, ucnt_q, ccnt_q;
  logic [pwidth-1:0] pkt_cnt_q;
  logic              bad_q, ram_vld_q, dval_q, full_q, af_q, drop_q, ovf_q;
  logic [width-1:0]  dout_q;
  logic              dout_eop_q;
  logic [DW-1:0]     wdata, ram_q;

  logic              wr_ok, acc, refuse, eop_in, commit, roll;
  logic              pop_fire, load_out, rd_en;
  logic [awidth:0]   used_n;

  always_comb begin
    wr_ok    = push & ~discard & ~flush;
    acc      = wr_ok & ~full_q;
    refuse   = wr_ok & full_q;
    eop_in   = wr_ok & din_eop;
    commit   = acc & din_eop & ~bad_q;
    // A refused eop always ends a bad packet, so it rolls back like a marked one.
    roll     = (discard & ~flush) | (eop_in & (bad_q | refuse));
    pop_fire = pop & dval_q;
    load_out = ram_vld_q & (~dval_q | pop_fire);
    rd_en    = (ccnt_q != '0) & (~ram_vld_q | load_out);
    used_n   = used_q + CW'(acc) - CW'(pop_fire) - (roll ? ucnt_q + CW'(acc) : '0);
  end

`ifdef NVME_PKT_FIFO_PARITY_EN
  logic par_q, perr_q;
  assign wdata = {even_par(PAR_MAX'({din_eop, din})), din_eop, din};
  assign perr  = perr_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      par_q  <= ZERO;
      perr_q <= ZERO;
    end else begin
      if (load_out) par_q <= ram_q[width+1];
      perr_q <= (perr_q & ~err_clr) |
                (dval_q & (par_q != even_par(PAR_MAX'({dout_eop_q, dout_q}))));
    end
  end
`else
  assign wdata = {din_eop, din};
  assign perr  = ZERO;
`endif

  nvme_fifo_ram #(
    .width  (DW),
    .words  (words),
    .awidth (awidth)
  ) u_ram (
    .clk   (clk),
    .we    (acc),
    .waddr (wptr_q),
    .wdata (wdata),
    .re    (rd_en),
    .raddr (rptr_q),
    .rdata (ram_q)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q     <= '0;
      cptr_q     <= '0;
      rptr_q     <= '0;
      used_q     <= '0;
      ucnt_q     <= '0;
      ccnt_q     <= '0;
      pkt_cnt_q  <= '0;
      bad_q      <= ZERO;
      ram_vld_q  <= ZERO;
      dval_q     <= ZERO;
      dout_q     <= '0;
      dout_eop_q <= ZERO;
      full_q     <= ZERO;
      af_q       <= AF_RST;
      drop_q     <= ZERO;
      ovf_q      <= ZERO;
    end else begin
      ovf_q <= (ovf_q & ~err_clr) | refuse;
      if (load_out) begin
        dout_q     <= ram_q[width-1:0];
        dout_eop_q <= ram_q[width];
      end
      if (flush) begin
        wptr_q    <= '0;
        cptr_q    <= '0;
        rptr_q    <= '0;
        used_q    <= '0;
        ucnt_q    <= '0;
        ccnt_q    <= '0;
        pkt_cnt_q <= '0;
        bad_q     <= ZERO;
        ram_vld_q <= ZERO;
        dval_q    <= ZERO;
        full_q    <= ZERO;
        af_q      <= AF_RST;
        drop_q    <= ZERO;
      end else begin
        if (roll)
          wptr_q <= cptr_q;
        else if (acc)
          wptr_q <= awidth'(next_ptr(32'(wptr_q), words));
        if (commit) cptr_q <= awidth'(next_ptr(32'(wptr_q), words));
        if (rd_en)  rptr_q <= awidth'(next_ptr(32'(rptr_q), words));
        used_q    <= used_n;
        ucnt_q    <= (commit | roll) ? '0 : ucnt_q + CW'(acc);
        ccnt_q    <= ccnt_q + (commit ? ucnt_q + CW'(1) : '0) - CW'(rd_en);
        pkt_cnt_q <= pkt_cnt_q + pwidth'(commit) - pwidth'(pop_fire & dout_eop_q);
        bad_q     <= roll ? ZERO : (refuse ? ONE : bad_q);
        ram_vld_q <= rd_en | (ram_vld_q & ~load_out);
        dval_q    <= load_out | (dval_q & ~pop_fire);
        full_q    <= (used_n >= DEPTH);
        af_q      <= (32'(DEPTH - used_n) <= almost_full_thresh);
        drop_q    <= eop_in & (bad_q | refuse);
      end
    end
  end

  assign dval        = dval_q;
  assign dout        = dout_q;
  assign dout_eop    = dout_eop_q;
  assign full        = full_q;
  assign almost_full = af_q;
  assign used        = used_q;
  assign pkt_cnt     = pkt_cnt_q;
  assign pkt_drop    = drop_q;
  assign overflow    = ovf_q;

endmodule
